// File: rtl/vam_pkg.sv
// Shared definitions for the VAM-16 operand/result sequencer.
package vam_pkg;

  localparam int unsigned VAM_OP_W  = 8;
  localparam int unsigned VAM_RES_W = 16;
  localparam int unsigned VAM_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_B = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } vam_state_t;

endpackage : vam_pkg

// File: rtl/vam_sequencer.sv
// Sequences two operands from a shared bus onto the VAM-16 datapath,
// waits the settle time, strobes readyFlag and captures the product.
module vam_sequencer
  import vam_pkg::*;
#(
  parameter int unsigned OP_W      = VAM_OP_W,
  parameter int unsigned RES_W     = VAM_RES_W,
  parameter int unsigned MULT_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startFlag,
  input  logic [OP_W-1:0]  inBus,
  output logic [OP_W-1:0]  outA,
  output logic [OP_W-1:0]  outB,
  output logic             readyFlag,
  input  logic [RES_W-1:0] inW,
  output logic [RES_W-1:0] result,
  output logic             resultValid,
  output logic             busy
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_LOAD_B = LOAD_B;
  localparam logic [1:0] S_WAIT   = WAIT;
  localparam logic [1:0] S_DONE   = DONE;

  localparam logic [VAM_CNT_W-1:0] CNT_INIT = VAM_CNT_W'(MULT_WAIT - 1);

  // Parameter legality is checked at elaboration.
  if (RES_W != 2 * OP_W) begin : g_bad_width
    $error("vam_sequencer: RES_W must equal 2*OP_W");
  end
  if (MULT_WAIT < 1 || MULT_WAIT > 15) begin : g_bad_wait
    $error("vam_sequencer: MULT_WAIT must be in 1..15");
  end

  logic [1:0]           state_q, state_d;
  logic [OP_W-1:0]      outa_q, outa_d;
  logic [OP_W-1:0]      outb_q, outb_d;
  logic [RES_W-1:0]     result_q, result_d;
  logic                 valid_q, valid_d;
  logic [VAM_CNT_W-1:0] cnt_q, cnt_d;

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    outa_d   = outa_q;
    outb_d   = outb_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (startFlag) begin
          outa_d  = inBus;
          state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        outb_d  = inBus;
        cnt_d   = CNT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - VAM_CNT_W'(1);
        end
      end
      S_DONE: begin
        result_d = inW;
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      outa_q   <= '0;
      outb_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      outa_q   <= outa_d;
      outb_q   <= outb_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign outA        = outa_q;
  assign outB        = outb_q;
  assign result      = result_q;
  assign resultValid = valid_q;
  assign busy        = (state_q != S_IDLE);
  assign readyFlag   = (state_q == S_DONE);

endmodule : vam_sequencer

// File: tb/tb_vam_sequencer.sv
// Bench for vam_sequencer: two instances (settle 1 and 3) share stimulus and
// are compared every cycle against a phase-based transaction model.
module tb_vam_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  bus = 8'h00;

  logic [7:0]  outa0, outb0, outa1, outb1;
  logic        rdy0, rdy1, vld0, vld1, bsy0, bsy1;
  logic [15:0] res0, res1, inw0, inw1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Datapath stand-in: unsigned product of the presented operands.
  assign inw0 = 16'(outa0) * 16'(outb0);
  assign inw1 = 16'(outa1) * 16'(outb1);

  vam_sequencer #(.OP_W(8), .RES_W(16), .MULT_WAIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .startFlag(start), .inBus(bus),
    .outA(outa0), .outB(outb0), .readyFlag(rdy0), .inW(inw0),
    .result(res0), .resultValid(vld0), .busy(bsy0)
  );

  vam_sequencer #(.OP_W(8), .RES_W(16), .MULT_WAIT(3)) u_dut3 (
    .clk(clk), .rst(rst), .startFlag(start), .inBus(bus),
    .outA(outa1), .outB(outb1), .readyFlag(rdy1), .inW(inw1),
    .result(res1), .resultValid(vld1), .busy(bsy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase k counts edges since start was accepted (-1 = idle, no pulse).
  // Busy for k in 0..1+W, ready at k=1+W, valid at k=2+W (already idle).
  int          mw [2] = '{1, 3};
  int          k  [2] = '{-1, -1};
  logic [7:0]  ma [2] = '{8'h00, 8'h00};
  logic [7:0]  mb [2] = '{8'h00, 8'h00};
  logic [15:0] mr [2] = '{16'h0, 16'h0};

  task automatic model_step(input int i);
    int kb;
    kb = k[i];
    if (rst) begin
      k[i] = -1; ma[i] = 8'h00; mb[i] = 8'h00; mr[i] = 16'h0;
    end else if (kb < 0 || kb >= 2 + mw[i]) begin
      if (start) begin
        k[i] = 0; ma[i] = bus;
      end else begin
        k[i] = -1;
      end
    end else if (kb == 0) begin
      mb[i] = bus; k[i] = 1;
    end else if (kb == 1 + mw[i]) begin
      mr[i] = 16'(ma[i]) * 16'(mb[i]); k[i] = 2 + mw[i];
    end else begin
      k[i] = kb + 1;
    end
  endtask

  task automatic compare_one(input int i, input logic [7:0] oa, input logic [7:0] ob,
                             input logic rdy, input logic [15:0] res,
                             input logic vld, input logic bsy);
    string p;
    p = (i == 0) ? "w1" : "w3";
    check({p, "_outA"},  32'(oa),  32'(ma[i]));
    check({p, "_outB"},  32'(ob),  32'(mb[i]));
    check({p, "_ready"}, 32'(rdy), 32'(k[i] == 1 + mw[i]));
    check({p, "_result"}, 32'(res), 32'(mr[i]));
    check({p, "_valid"}, 32'(vld), 32'(k[i] == 2 + mw[i]));
    check({p, "_busy"},  32'(bsy), 32'(k[i] >= 0 && k[i] < 2 + mw[i]));
  endtask

  // Per-cycle model advance and comparison, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    #1;
    compare_one(0, outa0, outb0, rdy0, res0, vld0, bsy0);
    compare_one(1, outa1, outb1, rdy1, res1, vld1, bsy1);
  end

  // One operation on both instances, with optional starts while busy.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit poke,
                       input logic [15:0] exp);
    int v0, v1, r0, r1;
    v0 = 0; v1 = 0; r0 = 0; r1 = 0;
    @(negedge clk); start = 1'b1; bus = a;
    @(negedge clk); start = poke; bus = b;
    @(negedge clk); start = poke; bus = poke ? 8'h33 : 8'($urandom);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      v0 += int'(vld0); v1 += int'(vld1);
      r0 += int'(rdy0); r1 += int'(rdy1);
      start = 1'b0; bus = 8'($urandom);
    end
    check("op_valid_cnt_w1", 32'(v0), 32'd1);
    check("op_valid_cnt_w3", 32'(v1), 32'd1);
    check("op_ready_cnt_w1", 32'(r0), 32'd1);
    check("op_ready_cnt_w3", 32'(r1), 32'd1);
    check("op_result_w1", 32'(res0), 32'(exp));
    check("op_result_w3", 32'(res1), 32'(exp));
    check("op_outA_held_w1", 32'(outa0), 32'(a));
    check("op_outB_held_w3", 32'(outb1), 32'(b));
  endtask

  initial begin : stim
    int v, first, gap;
    bit seen;

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outA", 32'(outa0), 32'h0);
    check("rst_outB", 32'(outb1), 32'h0);
    check("rst_result", 32'({res0, res1}), 32'h0);
    check("rst_flags", 32'({bsy0, rdy0, vld0, bsy1, rdy1, vld1}), 32'h0);
    rst = 1'b0;

    // Reset during WAIT: operation discarded, no pulse.
    @(negedge clk); start = 1'b1; bus = 8'd3;
    @(negedge clk); start = 1'b0; bus = 8'd5;
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    check("midrst_busy", 32'({bsy0, bsy1}), 32'h0);
    v = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); v += int'(vld0) + int'(vld1);
    end
    check("midrst_no_valid", 32'(v), 32'd0);
    check("midrst_result", 32'({res0, res1}), 32'h0);
    do_op(8'd3, 8'd5, 1'b0, 16'h000F);

    // Basic and boundary operands.
    do_op(8'h0C, 8'h0A, 1'b0, 16'h0078);
    do_op(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    do_op(8'h00, 8'hB7, 1'b0, 16'h0000);
    // Starts during LOAD_B and WAIT are ignored.
    do_op(8'h21, 8'h04, 1'b1, 16'h0084);

    // Back-to-back on the settle-3 instance: restart in the valid cycle.
    @(negedge clk); start = 1'b1; bus = 8'd7;
    @(negedge clk); start = 1'b0; bus = 8'd9;
    seen = 1'b0; first = 0;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(negedge clk);
      first++;
      if (vld1) seen = 1'b1;
      else bus = 8'($urandom);
    end
    check("b2b_first_seen", 32'(seen), 32'd1);
    check("b2b_first_result", 32'(res1), 32'h003F);
    start = 1'b1; bus = 8'd200;
    @(negedge clk); start = 1'b0; bus = 8'd100;
    gap = 1; seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(negedge clk);
      gap++;
      if (vld1) seen = 1'b1;
      else bus = 8'($urandom);
    end
    check("b2b_second_seen", 32'(seen), 32'd1);
    check("b2b_spacing", 32'(gap), 32'd6);
    check("b2b_second_result", 32'(res1), 32'h4E20);
    check("b2b_result_w1", 32'(res0), 32'h4E20);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 2) == 0);
      bus   = 8'($urandom);
    end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_vam_sequencer
